conv3x3_stream: RTL and testbench

//  Parametrised 3x3 streaming convolution stage for the edge-detection pipeline. Sits between two

---
 rtl/conv3x3_stream.sv | 177 +++++++++++++++++
 tb/tb_conv3x3_stream.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution between two show-ahead FIFOs: passthrough, Gaussian blur or Sobel
// magnitude per frame. Raster-order input; output (r,c) is written as input (r+1,c+1) is accepted.
module conv3x3_stream #(
    parameter int unsigned WIDTH  = 1280,
    parameter int unsigned HEIGHT = 720,
    parameter int unsigned PIX_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    output logic             in_rd_en,
    input  logic             in_empty,
    input  logic [PIX_W-1:0] in_dout,
    output logic             out_wr_en,
    input  logic             out_full,
    output logic [PIX_W-1:0] out_din,
    output logic             busy,
    output logic             frame_done
);
    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = $clog2(HEIGHT);
    localparam int unsigned SUM_W = PIX_W + 4;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
    localparam logic [SUM_W-1:0] PIX_MAX  = SUM_W'({PIX_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [1:0]       mode_q;
    logic [ROW_W-1:0] in_row, out_row;
    logic [COL_W-1:0] in_col, out_col;
    logic             accept, write, latch_mode;

    // Each entry holds {row-2, row-1} for its column.
    logic [2*PIX_W-1:0] line_buf [WIDTH];
    logic [2*PIX_W-1:0] lb_rd;
    logic [PIX_W-1:0]   win_q   [3][2];
    logic [PIX_W-1:0]   col_new [3];
    logic [PIX_W-1:0]   win     [3][3];

    logic [SUM_W-1:0] gauss_sum, gx_p, gx_n, gy_p, gy_n, gx_abs, gy_abs, mag;
    logic [PIX_W-1:0] filt_pix;
    logic             out_border;

    function automatic logic [SUM_W-1:0] tap121(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b,
                                                input logic [PIX_W-1:0] c);
        return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
    endfunction

    assign lb_rd = line_buf[in_col];

    always_comb begin
        col_new[0] = lb_rd[2*PIX_W-1:PIX_W];
        col_new[1] = lb_rd[PIX_W-1:0];
        col_new[2] = in_dout;
        for (int i = 0; i < 3; i++) begin
            win[i][0] = win_q[i][0];
            win[i][1] = win_q[i][1];
            win[i][2] = col_new[i];
        end
    end

    // Kernel arithmetic; both kernels are separable into [1 2 1] taps.
    always_comb begin
        gauss_sum = tap121(win[0][0], win[0][1], win[0][2])
                  + (tap121(win[1][0], win[1][1], win[1][2]) << 1)
                  + tap121(win[2][0], win[2][1], win[2][2]);
        gx_p   = tap121(win[0][2], win[1][2], win[2][2]);
        gx_n   = tap121(win[0][0], win[1][0], win[2][0]);
        gy_p   = tap121(win[2][0], win[2][1], win[2][2]);
        gy_n   = tap121(win[0][0], win[0][1], win[0][2]);
        gx_abs = (gx_p >= gx_n) ? gx_p - gx_n : gx_n - gx_p;
        gy_abs = (gy_p >= gy_n) ? gy_p - gy_n : gy_n - gy_p;
        mag    = gx_abs + gy_abs;
        case (mode_q)
            2'd1:    filt_pix = PIX_W'(gauss_sum >> 4);
            2'd2:    filt_pix = (mag > PIX_MAX) ? {PIX_W{1'b1}} : PIX_W'(mag);
            default: filt_pix = win[1][1];
        endcase
    end

    assign out_border = (out_row == '0) || (out_row == LAST_ROW) ||
                        (out_col == '0) || (out_col == LAST_COL);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        write      = 1'b0;
        latch_mode = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!in_empty) begin
                    latch_mode = 1'b1;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                accept = !in_empty;
                if (accept && in_row == ROW_W'(1) && in_col == '0) state_d = S_RUN;
            end
            S_RUN: begin
                accept = !in_empty && !out_full;
                write  = accept;
                if (accept && in_row == LAST_ROW && in_col == LAST_COL) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                write = !out_full;
                if (write && out_row == LAST_ROW && out_col == LAST_COL) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are gated by reset so an abort stops traffic in the same cycle.
    assign in_rd_en   = accept && reset;
    assign out_wr_en  = write && reset;
    assign out_din    = (out_wr_en && state_q == S_RUN && !out_border) ? filt_pix : '0;
    assign busy       = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_FLUSH);
    assign frame_done = (state_q == S_DONE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode_q  <= '0;
            in_row  <= '0;
            in_col  <= '0;
            out_row <= '0;
            out_col <= '0;
        end else begin
            if (latch_mode) mode_q <= mode;
            if (accept) begin
                if (in_col == LAST_COL) begin
                    in_col <= '0;
                    in_row <= (in_row == LAST_ROW) ? '0 : in_row + ROW_W'(1);
                end else begin
                    in_col <= in_col + COL_W'(1);
                end
            end
            if (write) begin
                if (out_col == LAST_COL) begin
                    out_col <= '0;
                    out_row <= (out_row == LAST_ROW) ? '0 : out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
            end
        end
    end

    // Line buffers and window are never cleared; border masking hides stale contents.
    always_ff @(posedge clock) begin
        if (in_rd_en) begin
            line_buf[in_col] <= {lb_rd[PIX_W-1:0], in_dout};
            for (int i = 0; i < 3; i++) begin
                win_q[i][0] <= win_q[i][1];
                win_q[i][1] <= col_new[i];
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: FIFO models on both sides, reference outputs computed
// from a whole-frame image array with plain kernel arithmetic.
module tb_conv3x3_stream;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int P    = 8;
    localparam int NPIX = W * H;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       in_rd_en, in_empty, out_wr_en, out_full, busy, frame_done;
    logic [P-1:0] in_dout, out_din;

    conv3x3_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(P)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
        .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int in_q[$];
    int exp_q[$];
    int img[H][W];
    int gap_pct = 0;
    int full_mode = 0;
    int total_accepts = 0;
    int frame_accepts = 0;
    int frames_done = 0;
    int wr_cnt = 0;
    bit prev_fd = 1'b0;

    int gk[3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    int sx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int sy[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_pix(input int m, input int r, input int c);
        int acc = 0;
        int gx = 0;
        int gy = 0;
        int mg;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                acc += gk[dy][dx] * img[r + dy - 1][c + dx - 1];
                gx  += sx[dy][dx] * img[r + dy - 1][c + dx - 1];
                gy  += sy[dy][dx] * img[r + dy - 1][c + dx - 1];
            end
        end
        case (m)
            1: return acc / 16;
            2: begin
                mg = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
                return (mg > 255) ? 255 : mg;
            end
            default: return img[r][c];
        endcase
    endfunction

    // pat: 0 ramp, 1 constant 100, 2 vertical step, 3 random
    task automatic load_frame(input int m, input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (pat)
                    0: img[r][c] = W * r + c;
                    1: img[r][c] = 100;
                    2: img[r][c] = (c < W / 2) ? 0 : 200;
                    default: img[r][c] = int'($urandom_range(255));
                endcase
            end
        end
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) exp_q.push_back(ref_pix(m, r, c));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) in_q.push_back(img[r][c]);
    endtask

    task automatic wait_frames(input int target);
        int cyc = 0;
        while (frames_done < target && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        check("frame_timeout", int'(frames_done >= target), 1);
        check("inputs_drained", in_q.size(), 0);
        check("outputs_drained", exp_q.size(), 0);
    endtask

    task automatic wait_accepts(input int target);
        int cyc = 0;
        while (total_accepts < target && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        check("accept_timeout", int'(total_accepts >= target), 1);
    endtask

    // Upstream and downstream FIFO models: drive on negedge, sample handshakes just before posedge.
    initial begin
        forever begin
            @(negedge clock);
            in_empty = (in_q.size() == 0) || (int'($urandom_range(99)) < gap_pct);
            in_dout  = in_empty ? P'($urandom) : P'(in_q[0]);
            case (full_mode)
                1: out_full = (int'($urandom_range(99)) < 30);
                2: out_full = 1'b1;
                3: out_full = ~out_full;
                default: out_full = 1'b0;
            endcase
            #4;
            if (!reset) begin
                in_q.delete();
                frame_accepts = 0;
            end else if (in_rd_en) begin
                check("rd_while_empty", int'(in_empty), 0);
                check("rd_while_full_in_run", int'(out_full && frame_accepts > W), 0);
                if (frame_accepts > W) check("run_accept_writes", int'(out_wr_en), 1);
                if (in_q.size() > 0) void'(in_q.pop_front());
                total_accepts++;
                frame_accepts++;
                if (frame_accepts == NPIX) frame_accepts = 0;
            end
        end
    end

    // Output monitor: pops the scoreboard on every write.
    initial begin
        int e;
        forever begin
            @(negedge clock);
            #4;
            if (!reset) begin
                exp_q.delete();
                wr_cnt  = 0;
                prev_fd = 1'b0;
            end else begin
                if (out_wr_en) begin
                    check("wr_while_full", int'(out_full), 0);
                    check("busy_during_write", int'(busy), 1);
                    check("unexpected_write", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("out_din", int'(out_din), e);
                    end
                    wr_cnt++;
                end
                if (frame_done) begin
                    check("writes_per_frame", wr_cnt, NPIX);
                    check("busy_at_done", int'(busy), 0);
                    check("done_single_pulse", int'(prev_fd), 0);
                    wr_cnt = 0;
                    frames_done++;
                end
                prev_fd = frame_done;
            end
        end
    end

    initial begin
        int base;
        int a0;
        int m;
        reset    = 1'b0;
        mode     = 2'd0;
        in_empty = 1'b1;
        in_dout  = '0;
        out_full = 1'b0;
        repeat (3) @(negedge clock);
        #4;
        check("reset_rd_en", int'(in_rd_en), 0);
        check("reset_wr_en", int'(out_wr_en), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_out_din", int'(out_din), 0);
        @(negedge clock);
        reset = 1'b1;

        // Passthrough ramp
        mode = 2'd0;
        load_frame(0, 0);
        wait_frames(1);

        // Gaussian on constant, with upstream gaps and downstream backpressure
        gap_pct = 25; full_mode = 1;
        mode = 2'd1;
        load_frame(1, 1);
        wait_frames(2);

        // Sobel on a vertical step
        mode = 2'd2;
        load_frame(2, 2);
        wait_frames(3);

        // Long full stall mid-RUN, then full toggling every cycle
        gap_pct = 0; full_mode = 0;
        mode = 2'd0;
        base = total_accepts;
        load_frame(0, 0);
        wait_accepts(base + 20);
        full_mode = 2;
        @(negedge clock);
        a0 = total_accepts;
        repeat (19) @(negedge clock);
        check("stall_no_accept", total_accepts, a0);
        full_mode = 3;
        wait_frames(4);
        full_mode = 0;

        // Abort mid-frame by reset, then a clean frame
        base = total_accepts;
        load_frame(0, 0);
        wait_accepts(base + 30);
        reset = 1'b0;
        @(negedge clock);
        #4;
        check("abort_rd_en", int'(in_rd_en), 0);
        check("abort_wr_en", int'(out_wr_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_no_extra_read", total_accepts, base + 30);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        load_frame(0, 0);
        wait_frames(5);

        // Mode change mid-frame is ignored; second frame back-to-back picks it up
        mode = 2'd0;
        base = total_accepts;
        load_frame(0, 0);
        wait_accepts(base + 15);
        mode = 2'd2;
        load_frame(2, 2);
        wait_frames(7);

        // Random images in random modes with random flow control
        gap_pct = 25; full_mode = 1;
        for (int i = 0; i < 4; i++) begin
            m = int'($urandom_range(3));
            mode = 2'(m);
            load_frame(m, 3);
            wait_frames(8 + i);
        end
        gap_pct = 0; full_mode = 0;
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
